// File: rtl/rv_trace_pkg.sv
// Shared definitions for the retirement trace buffer: record kinds,
// record layout and a record-packing helper.
package rv_trace_pkg;

    // Packed record: {kind[70:69], rd[68:64], addr[63:32], data[31:0]}
    localparam int REC_W    = 71;
    localparam int DATA_LSB = 0;
    localparam int ADDR_LSB = 32;
    localparam int RD_LSB   = 64;
    localparam int KIND_LSB = 69;

    typedef enum logic [1:0] {
        KIND_NONE = 2'b00,
        KIND_WB   = 2'b01,
        KIND_ST   = 2'b10
    } kind_e;

    // Assemble one trace record from its fields.
    function automatic logic [REC_W-1:0] make_rec(
        input kind_e       kind,
        input logic [4:0]  rd,
        input logic [31:0] addr,
        input logic [31:0] data
    );
        logic [REC_W-1:0] rec;
        rec                    = '0;
        rec[KIND_LSB +: 2]     = kind;
        rec[RD_LSB   +: 5]     = rd;
        rec[ADDR_LSB +: 32]    = addr;
        rec[DATA_LSB +: 32]    = data;
        return rec;
    endfunction

endpackage

// File: rtl/rv_trace_fifo.sv
// Show-ahead record FIFO with two write ports and one read port.
// Port 1 is only written together with port 0 and lands one slot after it.
// The caller guarantees writes fit and reads only happen when not empty.
module rv_trace_fifo
    import rv_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr0_en,
    input  logic [REC_W-1:0]         wr0_data,
    input  logic                     wr1_en,
    input  logic [REC_W-1:0]         wr1_data,
    input  logic                     rd_en,
    output logic [REC_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    wptr_p1;

    // Second write slot; wraps naturally because DEPTH is a power of 2.
    assign wptr_p1 = wptr_q + AW'(1);

    // Next-state pointers and occupancy.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (wr0_en && wr1_en) begin
            wptr_d = wptr_q + AW'(2);
        end else if (wr0_en) begin
            wptr_d = wptr_p1;
        end
        if (rd_en) begin
            rptr_d = rptr_q + AW'(1);
        end
        count_d = count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Record storage writes.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; count gates visibility, so stale contents are never observed.
        if (wr0_en) begin
            mem_q[wptr_q] <= wr0_data;
        end
        if (wr1_en) begin
            mem_q[wptr_p1] <= wr1_data;
        end
    end

    assign rd_data = mem_q[rptr_q];
    assign count   = count_q;

endmodule

// File: rtl/rv_trace_buf.sv
// Retirement trace buffer: captures register writebacks and stores from
// the core pipeline into a FIFO, dropping (and counting) records that
// do not fit in the space available at the start of the cycle.
module rv_trace_buf
    import rv_trace_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int FILTER_X0 = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trace_en,
    input  logic                    wb_valid,
    input  logic [4:0]              wb_rd,
    input  logic [31:0]             wb_data,
    input  logic                    st_valid,
    input  logic [31:0]             st_addr,
    input  logic [31:0]             st_data,
    output logic                    trace_valid,
    input  logic                    trace_ready,
    output logic [REC_W-1:0]        trace_data,
    output logic [$clog2(DEPTH):0]  count,
    input  logic                    clr_stats,
    output logic                    overflow,
    output logic [15:0]             drop_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             wb_ok, st_ok;
    logic             wb_fit, st_fit;
    logic             wb_drop, st_drop;
    logic [CW-1:0]    free_slots;
    logic [CW-1:0]    st_need;
    logic [1:0]       drops;
    logic             wr0_en, wr1_en;
    logic [REC_W-1:0] wb_rec, st_rec, wr0_data;
    logic             pop;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [16:0]      drop_sum;
    logic [15:0]      drop_base;

    assign wb_rec = make_rec(KIND_WB, wb_rd, 32'h0, wb_data);
    assign st_rec = make_rec(KIND_ST, 5'd0, st_addr, st_data);

    assign trace_valid = (count != '0);
    assign pop         = trace_valid && trace_ready;

    // Classify this cycle's events: which records fit, which are dropped,
    // and how they map onto the two FIFO write ports (writeback first).
    always_comb begin
        wb_ok      = wb_valid && trace_en && !((FILTER_X0 != 0) && (wb_rd == 5'd0));
        st_ok      = st_valid && trace_en;
        // A same-cycle pop does not free space for this cycle's pushes.
        free_slots = CW'(DEPTH) - count;
        st_need    = wb_ok ? CW'(2) : CW'(1);
        wb_fit     = wb_ok && (free_slots >= CW'(1));
        st_fit     = st_ok && (free_slots >= st_need);
        wb_drop    = wb_ok && !wb_fit;
        st_drop    = st_ok && !st_fit;
        drops      = {1'b0, wb_drop} + {1'b0, st_drop};
        wr0_en     = wb_fit || st_fit;
        wr0_data   = wb_fit ? wb_rec : st_rec;
        wr1_en     = wb_fit && st_fit;
    end

    // Drop statistics; clearing discards history but keeps this cycle's drops.
    always_comb begin
        drop_base  = clr_stats ? 16'h0 : drop_cnt_q;
        drop_sum   = {1'b0, drop_base} + {15'b0, drops};
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_d = (clr_stats ? 1'b0 : overflow_q) || (drops != 2'd0);
    end

    // Statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= 16'h0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    rv_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (st_rec),
        .rd_en    (pop),
        .rd_data  (trace_data),
        .count    (count)
    );

endmodule

// File: tb/tb_rv_trace_buf.sv
// Self-checking bench for rv_trace_buf: scoreboard of expected records
// compared at each accepted pop, plus per-scenario status checks.
module tb_rv_trace_buf;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_en;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        trace_valid;
    logic        trace_ready;
    logic [70:0] trace_data;
    logic [3:0]  count;
    logic        clr_stats;
    logic        overflow;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [70:0] exp_q [$];

    rv_trace_buf #(
        .DEPTH     (DEPTH),
        .FILTER_X0 (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trace_en    (trace_en),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_data  (trace_data),
        .count       (count),
        .clr_stats   (clr_stats),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [70:0] rec_wb(input logic [4:0] rd, input logic [31:0] d);
        return {2'b01, rd, 32'h0, d};
    endfunction

    function automatic logic [70:0] rec_st(input logic [31:0] a, input logic [31:0] d);
        return {2'b10, 5'd0, a, d};
    endfunction

    // Scoreboard: every accepted pop must match the oldest expected record.
    always @(negedge clk) begin
        if (!rst && trace_valid === 1'b1 && trace_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %h expected no record", trace_data);
            end else begin
                logic [70:0] exp_rec;
                exp_rec = exp_q.pop_front();
                if (trace_data !== exp_rec) begin
                    errors++;
                    $display("FAIL pop_data: got %h expected %h", trace_data, exp_rec);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        wb_valid  = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'h0;
        st_valid  = 1'b0;
        st_addr   = 32'h0;
        st_data   = 32'h0;
        clr_stats = 1'b0;
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [31:0] d, input bit expect_kept);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = d;
        if (expect_kept) exp_q.push_back(rec_wb(rd, d));
        step();
        drive_idle();
    endtask

    task automatic drain();
        trace_ready = 1'b1;
        for (int i = 0; i < 40 && count != 4'd0; i++) step();
        trace_ready = 1'b0;
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL drain_timeout: got count %0d expected 0", count);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_missing: got %0d records outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        trace_en = 1'b1;
        trace_ready = 1'b0;
        drive_idle();
        step();
        step();
        checks++;
        if (count !== 4'd0 || trace_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: got count %0d valid %b ovf %b drops %0d expected 0 0 0 0",
                     count, trace_valid, overflow, drop_cnt);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_wb();
        push_wb(5'd5, 32'h11, 1'b1);
        checks++;
        if (trace_valid !== 1'b1 || count !== 4'd1) begin
            errors++;
            $display("FAIL single_status: got valid %b count %0d expected 1 1", trace_valid, count);
        end
        checks++;
        if (trace_data !== {2'b01, 5'd5, 32'h0, 32'h11}) begin
            errors++;
            $display("FAIL single_data: got %h expected %h", trace_data, {2'b01, 5'd5, 32'h0, 32'h11});
        end
        drain();
    endtask

    task automatic test_dual_event();
        trace_ready = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hA;
        st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hB;
        exp_q.push_back(rec_wb(5'd3, 32'hA));
        exp_q.push_back(rec_st(32'h100, 32'hB));
        step();
        drive_idle();
        checks++;
        if (count !== 4'd2) begin
            errors++;
            $display("FAIL dual_count: got %0d expected 2", count);
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [70:0] head;
        for (int i = 0; i < 9; i++) push_wb(5'(i + 1), 32'hA000 + i, i < 8);
        checks++;
        if (count !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL overflow_status: got count %0d ovf %b drops %0d expected 8 1 1",
                     count, overflow, drop_cnt);
        end
        head = trace_data;
        checks++;
        if (head !== exp_q[0]) begin
            errors++;
            $display("FAIL overflow_head: got %h expected %h", head, exp_q[0]);
        end
        repeat (3) step();
        checks++;
        if (trace_data !== head || trace_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_stable: got %h expected %h", trace_data, head);
        end
        drain();
    endtask

    task automatic test_pop_full_dual();
        for (int i = 0; i < 7; i++) push_wb(5'(i + 10), 32'hB000 + i, 1'b1);
        trace_ready = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd20; wb_data = 32'hB0;
        st_valid = 1'b1; st_addr = 32'h200; st_data = 32'hC0;
        exp_q.push_back(rec_wb(5'd20, 32'hB0));
        step();
        drive_idle();
        trace_ready = 1'b0;
        checks++;
        if (count !== 4'd7 || drop_cnt !== 16'd2 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL pop_full_dual: got count %0d drops %0d ovf %b expected 7 2 1",
                     count, drop_cnt, overflow);
        end
        drain();
    endtask

    task automatic test_filter_clr();
        push_wb(5'd0, 32'hDEAD, 1'b0);
        checks++;
        if (count !== 4'd0 || trace_valid !== 1'b0 || drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL filter_x0: got count %0d valid %b drops %0d expected 0 0 2",
                     count, trace_valid, drop_cnt);
        end
        trace_en = 1'b0;
        push_wb(5'd4, 32'h44, 1'b0);
        trace_en = 1'b1;
        checks++;
        if (count !== 4'd0 || drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL trace_en_off: got count %0d drops %0d expected 0 2", count, drop_cnt);
        end
        clr_stats = 1'b1;
        step();
        drive_idle();
        checks++;
        if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL clr_stats: got ovf %b drops %0d expected 0 0", overflow, drop_cnt);
        end
        for (int i = 0; i < 9; i++) push_wb(5'(i + 1), 32'hC000 + i, i < 8);
        clr_stats = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
        st_valid = 1'b1; st_addr = 32'h300; st_data = 32'h33;
        step();
        drive_idle();
        checks++;
        if (overflow !== 1'b1 || drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL clr_with_drops: got ovf %b drops %0d expected 1 2", overflow, drop_cnt);
        end
        clr_stats = 1'b1;
        step();
        drive_idle();
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push_wb(5'(i + 1), 32'hD000 + i, 1'b1);
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL pre_reset_count: got %0d expected 5", count);
        end
        rst = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
        step();
        drive_idle();
        rst = 1'b0;
        exp_q.delete();
        checks++;
        if (count !== 4'd0 || trace_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got count %0d valid %b expected 0 0", count, trace_valid);
        end
        step();
        checks++;
        if (count !== 4'd0 || trace_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_event_ignored: got count %0d valid %b expected 0 0", count, trace_valid);
        end
    endtask

    task automatic test_random_stream();
        int mcount;
        int mdrops;
        int free_slots;
        bit w, s, rdy, wfit, sfit;
        logic [4:0]  rd;
        logic [31:0] d0, a1, d1;
        mcount = 0;
        mdrops = 0;
        for (int i = 0; i < 80; i++) begin
            w   = 1'($urandom_range(0, 1));
            s   = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 3) != 0);
            rd  = 5'($urandom_range(1, 31));
            d0  = $urandom();
            a1  = $urandom();
            d1  = $urandom();
            free_slots = DEPTH - mcount;
            wfit = w && free_slots >= 1;
            sfit = s && free_slots >= (w ? 2 : 1);
            if (wfit) exp_q.push_back(rec_wb(rd, d0));
            if (sfit) exp_q.push_back(rec_st(a1, d1));
            mdrops += int'(w && !wfit) + int'(s && !sfit);
            mcount = mcount + int'(wfit) + int'(sfit) - int'(rdy && mcount > 0);
            wb_valid = w; wb_rd = rd; wb_data = d0;
            st_valid = s; st_addr = a1; st_data = d1;
            trace_ready = rdy;
            step();
        end
        drive_idle();
        trace_ready = 1'b0;
        checks++;
        if (count !== 4'(mcount) || drop_cnt !== 16'(mdrops)) begin
            errors++;
            $display("FAIL random_status: got count %0d drops %0d expected %0d %0d",
                     count, drop_cnt, mcount, mdrops);
        end
        drain();
        clr_stats = 1'b1;
        step();
        drive_idle();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++) push_wb(5'(i + 1), 32'hE000 + i, 1'b1);
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h1;
        st_valid = 1'b1; st_addr = 32'h4; st_data = 32'h2;
        repeat (32768) step();
        checks++;
        if (drop_cnt !== 16'hFFFF || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drop_saturate: got drops %h ovf %b expected ffff 1", drop_cnt, overflow);
        end
        step();
        drive_idle();
        checks++;
        if (drop_cnt !== 16'hFFFF || count !== 4'd8) begin
            errors++;
            $display("FAIL drop_hold: got drops %h count %0d expected ffff 8", drop_cnt, count);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_wb();
        test_dual_event();
        test_overflow();
        test_pop_full_dual();
        test_filter_clr();
        test_reset_mid();
        test_random_stream();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
